// File: rtl/rect_flip_sequencer.sv
// Command sequencer for the rectangle-flip controller: sweeps every rectangle
// (r1<r2, c1<c2) of a ROWS x COLS matrix for a programmable number of passes.
module rect_flip_sequencer #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [7:0]       base_addr_in,
  input  logic [3:0]       passes,
  output logic             flip_start,
  output logic [7:0]       flip_base_addr,
  output logic [IDX_W-1:0] r1,
  output logic [IDX_W-1:0] r2,
  output logic [IDX_W-1:0] c1,
  output logic [IDX_W-1:0] c2,
  input  logic             flip_done,
  output logic             busy,
  output logic             all_done,
  output logic             error,
  output logic [9:0]       flip_count
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [WdW-1:0]   WdLast  = WdW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] RowMax  = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] RowMax2 = IDX_W'(ROWS - 2);
  localparam logic [IDX_W-1:0] ColMax  = IDX_W'(COLS - 1);
  localparam logic [IDX_W-1:0] ColMax2 = IDX_W'(COLS - 2);
  localparam logic [IDX_W-1:0] Idx0    = IDX_W'(0);
  localparam logic [IDX_W-1:0] Idx1    = IDX_W'(1);
  localparam logic [IDX_W-1:0] Idx2    = IDX_W'(2);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StAdvance,
    StFinish,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [7:0]       base_q, base_d;
  logic [3:0]       passes_q, passes_d;
  logic [3:0]       pass_cnt_q, pass_cnt_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [9:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] r1_q, r1_d, r2_q, r2_d, c1_q, c1_d, c2_q, c2_d;

  logic [IDX_W-1:0] nr1, nr2, nc1, nc2;
  logic             pass_wrap;
  logic [3:0]       pass_inc;
  logic             go_ok;

  assign go_ok    = go && ((state_q == StIdle) || (state_q == StErr));
  assign pass_inc = pass_cnt_q + 4'd1;

  // Successor rectangle in lexicographic order, c2 innermost.
  always_comb begin
    nr1       = r1_q;
    nr2       = r2_q;
    nc1       = c1_q;
    nc2       = c2_q;
    pass_wrap = 1'b0;
    if (c2_q < ColMax) begin
      nc2 = c2_q + Idx1;
    end else if (c1_q < ColMax2) begin
      nc1 = c1_q + Idx1;
      nc2 = c1_q + Idx2;
    end else if (r2_q < RowMax) begin
      nr2 = r2_q + Idx1;
      nc1 = Idx0;
      nc2 = Idx1;
    end else if (r1_q < RowMax2) begin
      nr1 = r1_q + Idx1;
      nr2 = r1_q + Idx2;
      nc1 = Idx0;
      nc2 = Idx1;
    end else begin
      nr1       = Idx0;
      nr2       = Idx1;
      nc1       = Idx0;
      nc2       = Idx1;
      pass_wrap = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StErr: begin
        if (go) state_d = (passes == 4'd0) ? StFinish : StIssue;
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (flip_done)         state_d = StAdvance;
        else if (wd_q == WdLast) state_d = StErr;
      end
      StAdvance: begin
        state_d = (pass_wrap && (pass_inc == passes_q)) ? StFinish : StIssue;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    base_d     = base_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    wd_d       = wd_q;
    cnt_d      = cnt_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    if (go_ok) begin
      base_d     = base_addr_in;
      passes_d   = passes;
      pass_cnt_d = 4'd0;
      cnt_d      = 10'd0;
      r1_d       = Idx0;
      r2_d       = Idx1;
      c1_d       = Idx0;
      c2_d       = Idx1;
    end
    unique case (state_q)
      StIssue: wd_d = '0;
      StWait: begin
        if (flip_done) cnt_d = cnt_q + 10'd1;
        else           wd_d  = wd_q + WdW'(1);
      end
      StAdvance: begin
        r1_d = nr1;
        r2_d = nr2;
        c1_d = nc1;
        c2_d = nc2;
        if (pass_wrap) pass_cnt_d = pass_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= 8'd0;
      passes_q   <= 4'd0;
      pass_cnt_q <= 4'd0;
      wd_q       <= '0;
      cnt_q      <= 10'd0;
      r1_q       <= Idx0;
      r2_q       <= Idx1;
      c1_q       <= Idx0;
      c2_q       <= Idx1;
    end else begin
      base_q     <= base_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
    end
  end

  always_comb begin
    flip_start = (state_q == StIssue);
    busy       = (state_q == StIssue) || (state_q == StWait) || (state_q == StAdvance);
    all_done   = (state_q == StFinish);
    error      = (state_q == StErr);
  end

  assign flip_base_addr = base_q;
  assign flip_count     = cnt_q;
  assign r1             = r1_q;
  assign r2             = r2_q;
  assign c1             = c1_q;
  assign c2             = c2_q;

endmodule

// File: tb/tb_rect_flip_sequencer.sv
// Directed/randomised bench for rect_flip_sequencer against a rectangle-list
// reference model and a behavioural flip-controller model.
module tb_rect_flip_sequencer;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 255;

  logic             clk;
  logic             rst_n;
  logic             go;
  logic [7:0]       base_addr_in;
  logic [3:0]       passes;
  logic             flip_start;
  logic [7:0]       flip_base_addr;
  logic [IDX_W-1:0] r1, r2, c1, c2;
  logic             flip_done;
  logic             busy;
  logic             all_done;
  logic             error;
  logic [9:0]       flip_count;

  int n_assert = 0;
  int n_fail   = 0;
  int nrect;
  logic [7:0] rects[$];

  rect_flip_sequencer #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .IDX_W  (IDX_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .base_addr_in  (base_addr_in),
    .passes        (passes),
    .flip_start    (flip_start),
    .flip_base_addr(flip_base_addr),
    .r1            (r1),
    .r2            (r2),
    .c1            (c1),
    .c2            (c2),
    .flip_done     (flip_done),
    .busy          (busy),
    .all_done      (all_done),
    .error         (error),
    .flip_count    (flip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted go followed by a sweep served by a controller model that returns
  // flip_done dly cycles after each flip_start; rectangle stall_at is never answered.
  task automatic sweep(input logic [7:0] addr, input logic [3:0] np, input int dly,
                       input int stall_at, input bit stray);
    int cyc, starts, last_start, done_at, ad_cnt, exp_starts;
    bit ended;
    exp_starts = (stall_at >= 0) ? stall_at + 1 : int'(np) * nrect;
    go = 1'b1; base_addr_in = addr; passes = np; flip_done = 1'b0;
    step();
    cyc = 0; starts = 0; last_start = -1; done_at = -1; ad_cnt = 0; ended = 1'b0;
    while (!ended && cyc < 3000) begin
      go = 1'b0;
      flip_done = 1'b0;
      check("busy", 32'(busy), 32'(!(all_done || error)));
      if (flip_start) begin
        check("rect", 32'({r1, r2, c1, c2}), 32'(rects[starts % nrect]));
        check("base", 32'(flip_base_addr), 32'(addr));
        check("cnt_at_start", 32'(flip_count), 32'(starts));
        if (last_start >= 0) check("spacing", cyc - last_start, dly + 2);
        last_start = cyc;
        if (starts != stall_at) done_at = cyc + dly;
        if (stray && starts == 10) begin
          go = 1'b1;
          base_addr_in = ~addr;
          flip_done = 1'b1;
        end
        starts++;
      end
      if (cyc == done_at) flip_done = 1'b1;
      if (all_done) begin
        ad_cnt++;
        ended = 1'b1;
        check("done_cnt", 32'(flip_count), int'(np) * nrect);
        if (np == 4'd0) check("zero_pass_lat", cyc, 0);
      end
      if (error) begin
        ended = 1'b1;
        if (stall_at < 0) begin
          check("unexpected_error", 32'(error), 0);
        end else begin
          check("err_latency", cyc - last_start, TIMEOUT + 1);
          check("err_busy", 32'(busy), 0);
          check("err_rect", 32'({r1, r2, c1, c2}), 32'(rects[stall_at]));
          check("err_cnt", 32'(flip_count), stall_at);
        end
      end
      if (!ended) begin
        step();
        cyc++;
      end
    end
    check("ended_in_budget", 32'(ended), 1);
    check("start_count", starts, exp_starts);
    check("all_done_count", ad_cnt, (stall_at >= 0) ? 0 : 1);
    go = 1'b0;
    flip_done = 1'b0;
    repeat (3) begin
      step();
      check("quiet_start", 32'(flip_start), 0);
      check("quiet_all_done", 32'(all_done), 0);
      check("quiet_busy", 32'(busy), 0);
    end
    if (stall_at >= 0) begin
      check("error_sticky", 32'(error), 1);
      check("err_hold_rect", 32'({r1, r2, c1, c2}), 32'(rects[stall_at]));
    end
  endtask

  initial begin
    int cyc, starts, done_at;
    logic [3:0] rp;

    // Reference rectangle list, straight from the r1<r2, c1<c2 enumeration.
    for (int a = 0; a < ROWS - 1; a++)
      for (int b = a + 1; b < ROWS; b++)
        for (int c = 0; c < COLS - 1; c++)
          for (int d = c + 1; d < COLS; d++)
            rects.push_back({2'(a), 2'(b), 2'(c), 2'(d)});
    nrect = rects.size();

    rst_n = 1'b0; go = 1'b0; base_addr_in = 8'h00; passes = 4'd0; flip_done = 1'b0;
    repeat (3) step();
    check("rst_flip_start", 32'(flip_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_all_done", 32'(all_done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_count", 32'(flip_count), 0);
    check("rst_base", 32'(flip_base_addr), 0);
    check("rst_rect", 32'({r1, r2, c1, c2}), 32'(8'b00_01_00_01));
    rst_n = 1'b1;
    step();

    // Stray flip_done while idle.
    flip_done = 1'b1;
    repeat (3) step();
    flip_done = 1'b0;
    step();
    check("idle_stray_cnt", 32'(flip_count), 0);
    check("idle_stray_start", 32'(flip_start), 0);

    sweep(8'h40, 4'd1, 3, -1, 1'b0);

    flip_done = 1'b1;
    repeat (2) step();
    flip_done = 1'b0;
    step();
    check("idle_stray_cnt2", 32'(flip_count), nrect);

    sweep(8'h55, 4'd0, 1, -1, 1'b0);
    sweep(8'h9A, 4'd3, 1, -1, 1'b1);
    sweep(8'h21, 4'd1, 2, 4, 1'b0);
    sweep(8'h22, 4'd1, 1, -1, 1'b0);

    // Random address/pass count/latency sweeps.
    repeat (2) begin
      rp = 4'($urandom_range(1, 2));
      sweep(8'($urandom), rp, int'($urandom_range(1, 4)), -1, 1'($urandom));
    end

    // Asynchronous reset while waiting on the controller.
    go = 1'b1; base_addr_in = 8'h77; passes = 4'd2;
    step();
    go = 1'b0;
    cyc = 0; starts = 0; done_at = -1;
    while (starts < 4 && cyc < 200) begin
      flip_done = (cyc == done_at);
      if (flip_start) begin
        starts++;
        done_at = cyc + 1;
      end
      step();
      cyc++;
    end
    flip_done = 1'b0;
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_cnt", 32'(flip_count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_count", 32'(flip_count), 0);
    check("arst_base", 32'(flip_base_addr), 0);
    check("arst_rect", 32'({r1, r2, c1, c2}), 32'(8'b00_01_00_01));
    check("arst_flip_start", 32'(flip_start), 0);
    check("arst_error", 32'(error), 0);
    check("arst_all_done", 32'(all_done), 0);
    repeat (2) step();
    rst_n = 1'b1;
    starts = 0;
    repeat (20) begin
      step();
      if (flip_start) starts++;
    end
    check("post_rst_no_start", starts, 0);
    check("post_rst_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
